// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing control for the 5-stage pipeline.
// Keeps a decoded metadata shadow of the ID/EX/MEM/WB instructions and
// derives stage enables, bubbles/flushes, EX forwarding selects and a
// saturating count of PC-stall cycles. Carries no data values.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clkwire,
    input  logic             rst,
    input  logic [19:0]      if_instr,
    input  logic             if_valid,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [3:0]       stage_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr;
        logic       rd1;
        logic       rd2;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       load;
    } shadow_t;

    localparam shadow_t NOP_ENTRY = '0;

    shadow_t id_q, ex_q, mem_q, wb_q;
    logic    load_use;

    // Opcode class -> register read/write/load flags.
    function automatic shadow_t decode(input logic [19:0] instr);
        shadow_t e;
        e       = '0;
        e.valid = 1'b1;
        e.rd    = instr[15:12];
        e.rs1   = instr[11:8];
        e.rs2   = instr[7:4];
        case (instr[19:16])
            4'h0, 4'h7: ;
            4'h3: begin
                e.rd1 = 1'b1;
                e.wr  = 1'b1;
            end
            4'h4: begin
                e.rd1  = 1'b1;
                e.wr   = 1'b1;
                e.load = 1'b1;
            end
            4'h5, 4'h6: begin
                e.rd1 = 1'b1;
                e.rd2 = 1'b1;
            end
            default: begin
                e.rd1 = 1'b1;
                e.rd2 = 1'b1;
                e.wr  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Forwarding source for one EX operand; a load in MEM never forwards.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] src,
                                           input shadow_t mem_e, input shadow_t wb_e);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (mem_e.valid && mem_e.wr && !mem_e.load && mem_e.rd == src)
                sel = 2'b01;
            else if (wb_e.valid && wb_e.wr && wb_e.rd == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    // Hazard detection and stage control, priority mem_busy > branch > load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        load_use     = ex_q.valid && ex_q.load && ex_q.wr && id_q.valid &&
                       ((id_q.rd1 && id_q.rs1 == ex_q.rd) ||
                        (id_q.rd2 && id_q.rs2 == ex_q.rd));
        if (mem_busy) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
        fwd_a       = fwd_sel(ex_q.rd1, ex_q.rs1, mem_q, wb_q);
        fwd_b       = fwd_sel(ex_q.rd2, ex_q.rs2, mem_q, wb_q);
        stage_valid = {wb_q.valid, mem_q.valid, ex_q.valid, id_q.valid};
    end

    // Shadow registers advance under the same enables as the datapath.
    always_ff @(posedge clkwire or posedge rst) begin
        if (rst) begin
            id_q  <= NOP_ENTRY;
            ex_q  <= NOP_ENTRY;
            mem_q <= NOP_ENTRY;
            wb_q  <= NOP_ENTRY;
        end else begin
            if (ifid_en)
                id_q <= (if_valid && !ifid_flush) ? decode(if_instr) : NOP_ENTRY;
            if (exmem_en) begin
                ex_q  <= idex_bubble ? NOP_ENTRY : id_q;
                mem_q <= ex_q;
            end
            wb_q <= memwb_bubble ? NOP_ENTRY : mem_q;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clkwire or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against an
// instruction-level pipeline model.
module tb_pipeline_ctrl;

    logic        clkwire = 1'b0;
    logic        rst     = 1'b0;
    logic [19:0] if_instr = '0;
    logic        if_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [3:0]  stage_valid;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: per stage (0=ID,1=EX,2=MEM,3=WB) a valid bit and raw instruction word.
    bit          mv [4];
    logic [19:0] mi [4];
    int unsigned m_cnt;
    logic        e_pc, e_ifid, e_flush, e_bub, e_exmem, e_mwb, e_luse;
    logic [1:0]  e_fa, e_fb;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clkwire(clkwire), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
    );

    always #5 clkwire = ~clkwire;

    function automatic logic [3:0] f_op(input logic [19:0] i); return i[19:16]; endfunction
    function automatic bit reads1(input logic [19:0] i); return !(f_op(i) inside {4'h0, 4'h7}); endfunction
    function automatic bit reads2(input logic [19:0] i); return !(f_op(i) inside {4'h0, 4'h3, 4'h4, 4'h7}); endfunction
    function automatic bit writes(input logic [19:0] i); return !(f_op(i) inside {4'h0, 4'h5, 4'h6, 4'h7}); endfunction
    function automatic bit is_ld(input logic [19:0] i); return f_op(i) == 4'h4; endfunction

    function automatic logic [19:0] rand_instr();
        logic [19:0] r;
        r[19:16] = 4'($urandom_range(0, 15));
        r[15:12] = 4'($urandom_range(0, 3));
        r[11:8]  = 4'($urandom_range(0, 3));
        r[7:4]   = 4'($urandom_range(0, 3));
        r[3:0]   = 4'($urandom);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mv[s] = 1'b0;
            mi[s] = '0;
        end
        m_cnt = 0;
    endtask

    function automatic logic [1:0] m_fwd(input bit used, input logic [3:0] src);
        if (!used) return 2'b00;
        if (mv[2] && writes(mi[2]) && !is_ld(mi[2]) && mi[2][15:12] == src) return 2'b01;
        if (mv[3] && writes(mi[3]) && mi[3][15:12] == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        e_luse = mv[1] && is_ld(mi[1]) && writes(mi[1]) && mv[0] &&
                 ((reads1(mi[0]) && mi[0][11:8] == mi[1][15:12]) ||
                  (reads2(mi[0]) && mi[0][7:4] == mi[1][15:12]));
        {e_pc, e_ifid, e_flush, e_bub, e_exmem, e_mwb} = 6'b110010;
        if (mem_busy)          {e_pc, e_ifid, e_flush, e_bub, e_exmem, e_mwb} = 6'b000001;
        else if (branch_taken) {e_pc, e_ifid, e_flush, e_bub, e_exmem, e_mwb} = 6'b111110;
        else if (e_luse)       {e_pc, e_ifid, e_flush, e_bub, e_exmem, e_mwb} = 6'b000110;
        e_fa = m_fwd(mv[1] && reads1(mi[1]), mi[1][11:8]);
        e_fb = m_fwd(mv[1] && reads2(mi[1]), mi[1][7:4]);
    endtask

    task automatic model_adv();
        if (!e_pc && m_cnt < 32'hFFFF) m_cnt++;
        if (mem_busy) begin
            mv[3] = 1'b0; mi[3] = '0;
        end else begin
            mv[3] = mv[2]; mi[3] = mi[2];
            mv[2] = mv[1]; mi[2] = mi[1];
            if (branch_taken || e_luse) begin
                mv[1] = 1'b0; mi[1] = '0;
            end else begin
                mv[1] = mv[0]; mi[1] = mi[0];
            end
            if (branch_taken || !e_luse) begin
                if (if_valid && !branch_taken) begin
                    mv[0] = 1'b1; mi[0] = if_instr;
                end else begin
                    mv[0] = 1'b0; mi[0] = '0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("ifid_en", 32'(ifid_en), 32'(e_ifid));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("exmem_en", 32'(exmem_en), 32'(e_exmem));
        chk("memwb_bubble", 32'(memwb_bubble), 32'(e_mwb));
        chk("fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("stage_valid", 32'(stage_valid), 32'({mv[3], mv[2], mv[1], mv[0]}));
        chk("stall_cnt", 32'(stall_cnt), m_cnt);
    endtask

    task automatic drive(input logic [19:0] ins, input logic v, input logic br, input logic busy);
        @(negedge clkwire);
        if_instr = ins; if_valid = v; branch_taken = br; mem_busy = busy;
        #1;
        model_eval();
        check_all();
    endtask

    task automatic tick();
        @(posedge clkwire);
        model_adv();
    endtask

    task automatic step(input logic [19:0] ins, input logic v, input logic br, input logic busy);
        drive(ins, v, br, busy);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clkwire);
        if_instr = '0; if_valid = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_exmem_en", 32'(exmem_en), 32'd1);
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clkwire);
        #1 rst = 1'b0;
    endtask

    localparam logic [19:0] ADD1 = 20'h11230;  // ADD r1,r2,r3
    localparam logic [19:0] ADD2 = 20'h14150;  // ADD r4,r1,r5
    localparam logic [19:0] LD2  = 20'h42000;  // LD r2,(r0)
    localparam logic [19:0] ADD3 = 20'h13220;  // ADD r3,r2,r2
    localparam logic [19:0] BEQ  = 20'h60120;  // BEQ r1,r2

    initial begin
        model_reset();

        // EX/MEM forwarding of a back-to-back ALU result.
        do_reset();
        step(ADD1, 1, 0, 0);
        step(ADD2, 1, 0, 0);
        step(20'h0, 0, 0, 0);
        drive(20'h0, 0, 0, 0);
        chk("t1_fwd_a", 32'(fwd_a), 32'd1);
        chk("t1_fwd_b", 32'(fwd_b), 32'd0);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // Load-use: one bubble, then MEM/WB forwarding of the load.
        do_reset();
        step(LD2, 1, 0, 0);
        step(ADD3, 1, 0, 0);
        drive(20'h0, 0, 0, 0);
        chk("t2_pc_en", 32'(pc_en), 32'd0);
        chk("t2_idex_bubble", 32'(idex_bubble), 32'd1);
        tick();
        step(20'h0, 0, 0, 0);
        drive(20'h0, 0, 0, 0);
        chk("t2_fwd_a", 32'(fwd_a), 32'd2);
        chk("t2_fwd_b", 32'(fwd_b), 32'd2);
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Taken branch squashes ID and EX.
        do_reset();
        step(BEQ, 1, 0, 0);
        step(ADD1, 1, 0, 0);
        drive(ADD2, 1, 1, 0);
        chk("t3_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("t3_idex_bubble", 32'(idex_bubble), 32'd1);
        chk("t3_pc_en", 32'(pc_en), 32'd1);
        tick();
        drive(20'h0, 0, 0, 0);
        chk("t3_valid_lo", 32'(stage_valid[1:0]), 32'd0);
        tick();

        // Memory busy for 3 cycles with ADD1 in MEM.
        do_reset();
        step(ADD1, 1, 0, 0);
        step(ADD2, 1, 0, 0);
        step(BEQ, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(ADD3, 1, 0, 1);
            chk("t4_exmem_en", 32'(exmem_en), 32'd0);
            chk("t4_memwb_bubble", 32'(memwb_bubble), 32'd1);
            tick();
        end
        drive(20'h0, 0, 0, 0);
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t4_valid_held", 32'(stage_valid), 32'b0111);
        tick();
        drive(20'h0, 0, 0, 0);
        chk("t4_valid_resume", 32'(stage_valid), 32'b1110);
        tick();

        // Counter saturation: busy until 0xFFFE, then 3 more busy cycles.
        while (m_cnt < 32'hFFFE) step(20'h0, 0, 0, 1);
        drive(20'h0, 0, 0, 0);
        chk("t5_cnt_fffe", 32'(stall_cnt), 32'hFFFE);
        tick();
        for (int k = 0; k < 3; k++) step(20'h0, 0, 0, 1);
        drive(20'h0, 0, 0, 0);
        chk("t5_cnt_sat", 32'(stall_cnt), 32'hFFFF);
        tick();

        // Asynchronous reset in the middle of a load-use stall.
        step(LD2, 1, 0, 0);
        step(ADD3, 1, 0, 0);
        drive(20'h0, 0, 0, 0);
        chk("t6_stalled", 32'(pc_en), 32'd0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_pc_en", 32'(pc_en), 32'd1);
        chk("t6_ifid_en", 32'(ifid_en), 32'd1);
        chk("t6_idex_bubble", 32'(idex_bubble), 32'd0);
        chk("t6_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("t6_stage_valid", 32'(stage_valid), 32'd0);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clkwire);
        #1 rst = 1'b0;
        step(ADD1, 1, 0, 0);
        drive(20'h0, 0, 0, 0);
        chk("t6_first_load", 32'(stage_valid), 32'b0001);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++)
            step(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps a metadata shadow of every in-flight instruction and drives the stage-register enables, bubble and flush controls, and EX-stage operand forwarding selects. It handles load-use stalls, branch/jump flushes and memory-busy freezes. It sits beside the `id_unit`/`Execution_unit`/`memory_unit` datapath and owns no data values, only control.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clkwire` in 1: pipeline clock; every state element updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `if_instr` in 20: instruction currently at the IF/ID input.
- `if_valid` in 1: `if_instr` is a real instruction. When low, IF injects a NOP.
- `branch_taken` in 1: the EX-stage BEQ or JMP redirects the PC this cycle.
- `mem_busy` in 1: the MEM stage needs another cycle.
- `pc_en` out 1: PC update enable.
- `ifid_en` out 1: IF/ID register load enable.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_bubble` out 1: ID/EX loads a NOP.
- `exmem_en` out 1: ID/EX and EX/MEM load enable.
- `memwb_bubble` out 1: MEM/WB loads a NOP.
- `fwd_a` out 2: EX operand A source. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
- `fwd_b` out 2: EX operand B source, same encoding as `fwd_a`.
- `stage_valid` out 4: valid bits for {WB, MEM, EX, ID}, MSB = WB.
- `stall_cnt` out `CNT_W`: number of cycles in which `pc_en` was 0.

## Operation
- Instruction fields: opcode[19:16], rd[15:12], rs1[11:8], rs2[7:4], imm[7:0]. Register indices are compared on all 4 bits.
- Opcode classes:
  - 0000 NOP: reads nothing, writes nothing.
  - 0011 ADDI: reads rs1, writes rd.
  - 0100 LD: reads rs1, writes rd, flagged as a load.
  - 0101 ST: reads rs1 and rs2, writes nothing.
  - 0110 BEQ: reads rs1 and rs2, writes nothing.
  - 0111 JMP: reads nothing, writes nothing.
  - All other opcodes are ALU reg-reg: read rs1 and rs2, write rd.
- Shadow registers for ID, EX, MEM and WB each hold {valid, rd, wr, rd1, rd2, rs1, rs2, load}. They advance in lockstep with the datapath registers under the same enables.
- Load-use hazard: the EX instruction is a valid load with wr set, and the ID instruction reads its rd through rs1 (rd1) or rs2 (rd2). Response: `pc_en`=0, `ifid_en`=0, `idex_bubble`=1. This gives exactly one bubble.
- Branch: `branch_taken`=1 gives `ifid_flush`=1 and `idex_bubble`=1. `pc_en`=1 so the target is fetched. Two instructions are squashed.
- Memory busy: `mem_busy`=1 gives `pc_en`=`ifid_en`=`exmem_en`=0 and `memwb_bubble`=1. All stages up to MEM freeze.
- Priority: `mem_busy` > `branch_taken` > load-use. While `mem_busy` is high, `branch_taken` is held by the frozen EX stage and takes effect on the first non-busy cycle.
- Forwarding for the EX instruction, per operand:
  - Select 01 if MEM is valid, MEM.wr is set, MEM is not a load, and MEM.rd matches the source register.
  - Otherwise select 10 if WB is valid, WB.wr is set, and WB.rd matches.
  - Otherwise select 00.
  - When both MEM and WB match, MEM wins.
  - A load in MEM never forwards; the load-use stall guarantees it has reached WB before it is needed.
  - Operands that are not read get 00.
- `stall_cnt` increments in every cycle with `pc_en`=0 and saturates at all-ones.

## Timing
- All outputs are combinational from the shadow state and inputs. Shadow state and `stall_cnt` update on `posedge clkwire`.
- Reset (asynchronous, `rst`=1): all shadow entries are invalid NOPs and `stall_cnt`=0. The outputs then read `pc_en`=1, `ifid_en`=1, `exmem_en`=1, all flush/bubble outputs 0, `fwd_a`=`fwd_b`=00, `stage_valid`=0000.
- Reset asserted mid-stall clears everything immediately. The first edge after release loads `if_instr` into ID.
- An instruction entering ID at edge n reaches WB at edge n+3 when there are no stalls.
- The ID valid bit is loaded with `if_valid & ~ifid_flush`.
- `branch_taken` and a load-use hazard in the same cycle: the branch wins, and the stalled ID instruction is flushed.

## Test plan
- Reset then stream ADD r1,r2,r3 / ADD r4,r1,r5: on the cycle the second instruction is in EX, `fwd_a`=01 and `fwd_b`=00. No stall; `stall_cnt`=0.
- LD r2 then ADD r3,r2,r2 (back-to-back): one cycle of `pc_en`=0 and `idex_bubble`=1. The ADD later shows `fwd_a`=`fwd_b`=10 in EX. `stall_cnt`=1.
- BEQ with `branch_taken`=1 in EX: in that cycle `ifid_flush`=1, `idex_bubble`=1, `pc_en`=1. Next cycle `stage_valid`[1:0]=00.
- `mem_busy` held for 3 cycles during an ADD in MEM: `exmem_en`=0 and `memwb_bubble`=1 for 3 cycles, `stall_cnt`=3. The pipeline resumes without losing any instruction.
- Preload `stall_cnt` to 0xFFFE, then 3 busy cycles: `stall_cnt` holds at 0xFFFF.
- Assert `rst` during a load-use stall: all outputs return to their reset values asynchronously, before the next clock edge.
